// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings for the D-stage hazard scoreboard: Tuse/Tnew codes,
// HI/LO latencies, CP0 indices and stall_cause bit positions.
package hazard_scoreboard_pkg;

    localparam int unsigned DEF_MULT_CYCLES = 5;
    localparam int unsigned DEF_DIV_CYCLES  = 10;
    localparam int unsigned CAUSE_W         = 4;

    typedef enum logic [1:0] {
        TUSE_D    = 2'd0,
        TUSE_E    = 2'd1,
        TUSE_M    = 2'd2,
        TUSE_NONE = 2'd3
    } tuse_e;

    typedef enum logic [1:0] {
        TNEW_READY = 2'd0,
        TNEW_ALU   = 2'd1,
        TNEW_LOAD  = 2'd2,
        TNEW_LONG  = 2'd3
    } tnew_e;

    typedef enum logic [4:0] {
        CP0_SR    = 5'd12,
        CP0_CAUSE = 5'd13,
        CP0_EPC   = 5'd14
    } cp0_idx_e;

    typedef enum int unsigned {
        CAUSE_RS   = 0,
        CAUSE_RT   = 1,
        CAUSE_HILO = 2,
        CAUSE_ERET = 3
    } cause_bit_e;

endpackage

// File: rtl/hazard_scoreboard_hilo_busy_ctr.sv
// HI/LO unit busy counter: loaded with latency+1 when mult/div issues,
// then counts down; busy while nonzero.
module hilo_busy_ctr
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    localparam int unsigned CW = $clog2(DIV_CYCLES + 2);

    logic [CW-1:0] mdc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mdc <= '0;
        end else if (start) begin
            mdc <= is_div ? CW'(DIV_CYCLES + 1) : CW'(MULT_CYCLES + 1);
        end else if (mdc != '0) begin
            mdc <= mdc - CW'(1);
        end
    end

    assign busy = (mdc != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// D-stage hazard scoreboard: per-GPR Tnew countdown compared against
// operand Tuse, plus HI/LO busy and the mtc0-EPC -> eret guard window.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned NREG        = 32,
    parameter int unsigned TW          = 2,
    parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES,
    parameter int unsigned EPC_ADDR    = CP0_EPC,
    parameter int unsigned EPC_WIN     = 2,
    localparam int unsigned AW         = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                d_valid,
    input  logic [AW-1:0]       d_rs,
    input  logic [AW-1:0]       d_rt,
    input  logic [TW-1:0]       d_tuse_rs,
    input  logic [TW-1:0]       d_tuse_rt,
    input  logic                d_wr,
    input  logic [AW-1:0]       d_dst,
    input  logic [TW-1:0]       d_tnew,
    input  logic                d_md_start,
    input  logic                d_md_div,
    input  logic                d_md_use,
    input  logic                d_mtc0,
    input  logic [4:0]          d_cp0_rd,
    input  logic                d_eret,
    input  logic                flush,
    output logic                stall,
    output logic [CAUSE_W-1:0]  stall_cause,
    output logic                md_busy,
    output logic [NREG-1:0]     pending
);

    localparam int unsigned EW = (EPC_WIN < 1) ? 1 : $clog2(EPC_WIN + 1);

    logic [TW-1:0] sb [NREG];
    logic [EW-1:0] ec;
    logic          issue;
    logic          sb_load;
    logic          stall_rs, stall_rt, stall_hilo, stall_eret;

    assign stall_rs   = d_valid & (d_rs != '0) & (d_tuse_rs < sb[d_rs]);
    assign stall_rt   = d_valid & (d_rt != '0) & (d_tuse_rt < sb[d_rt]);
    assign stall_hilo = d_valid & d_md_use & md_busy;
    assign stall_eret = d_valid & d_eret & (ec != '0);

    always_comb begin
        stall_cause             = '0;
        stall_cause[CAUSE_RS]   = stall_rs;
        stall_cause[CAUSE_RT]   = stall_rt;
        stall_cause[CAUSE_HILO] = stall_hilo;
        stall_cause[CAUSE_ERET] = stall_eret;
    end

    assign stall   = |stall_cause;
    assign issue   = d_valid & ~stall & ~flush;
    assign sb_load = issue & d_wr & (d_dst != '0);

    // A load replaces the decrement for its entry; r0 is pinned at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned r = 0; r < NREG; r++) sb[r] <= '0;
        end else begin
            for (int unsigned r = 0; r < NREG; r++) begin
                if (r == 0 || flush) begin
                    sb[r] <= '0;
                end else if (sb_load && d_dst == AW'(r)) begin
                    sb[r] <= d_tnew;
                end else if (sb[r] != '0) begin
                    sb[r] <= sb[r] - TW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ec <= '0;
        end else if (flush) begin
            ec <= '0;
        end else if (issue && d_mtc0 && d_cp0_rd == 5'(EPC_ADDR)) begin
            ec <= EW'(EPC_WIN);
        end else if (ec != '0) begin
            ec <= ec - EW'(1);
        end
    end

    always_comb begin
        pending = '0;
        for (int unsigned r = 0; r < NREG; r++) pending[r] = (sb[r] != '0);
    end

    hilo_busy_ctr #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_hilo_busy_ctr (
        .clk    (clk),
        .reset  (reset),
        .start  (issue & d_md_start),
        .is_div (d_md_div),
        .busy   (md_busy)
    );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: timestamp-based reference model checked every
// cycle, plus directed instruction pairs with hand-computed stall counts.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    localparam int NREG = 32;
    localparam int MULT = 5;
    localparam int DIV  = 10;
    localparam int EWIN = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        d_valid, d_wr, d_md_start, d_md_div, d_md_use, d_mtc0, d_eret, flush;
    logic [4:0]  d_rs, d_rt, d_dst, d_cp0_rd;
    logic [1:0]  d_tuse_rs, d_tuse_rt, d_tnew;
    logic        stall, md_busy;
    logic [3:0]  stall_cause;
    logic [NREG-1:0] pending;

    int n_checks = 0;
    int n_fails  = 0;

    // Model state: absolute cycle at which each hazard clears.
    int cyc = 0;
    int ready [NREG] = '{default: 0};
    int md_free = 0;
    int ec_free = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .NREG(NREG), .TW(2), .MULT_CYCLES(MULT), .DIV_CYCLES(DIV),
        .EPC_ADDR(14), .EPC_WIN(EWIN)
    ) dut (
        .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
        .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_wr(d_wr), .d_dst(d_dst),
        .d_tnew(d_tnew), .d_md_start(d_md_start), .d_md_div(d_md_div),
        .d_md_use(d_md_use), .d_mtc0(d_mtc0), .d_cp0_rd(d_cp0_rd), .d_eret(d_eret),
        .flush(flush), .stall(stall), .stall_cause(stall_cause), .md_busy(md_busy),
        .pending(pending)
    );

    function automatic int rem(input int t);
        return (t > cyc) ? t - cyc : 0;
    endfunction

    function automatic logic [3:0] exp_cause();
        logic [3:0] c;
        c = '0;
        if (d_valid) begin
            c[0] = (d_rs != 0) && (int'(d_tuse_rs) < rem(ready[d_rs]));
            c[1] = (d_rt != 0) && (int'(d_tuse_rt) < rem(ready[d_rt]));
            c[2] = d_md_use && (rem(md_free) != 0);
            c[3] = d_eret && (rem(ec_free) != 0);
        end
        return c;
    endfunction

    function automatic logic [NREG-1:0] exp_pending();
        logic [NREG-1:0] p;
        p = '0;
        for (int r = 1; r < NREG; r++) p[r] = (rem(ready[r]) != 0);
        return p;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREG; r++) ready[r] <= 0;
            md_free <= 0;
            ec_free <= 0;
        end else if (flush) begin
            for (int r = 0; r < NREG; r++) ready[r] <= 0;
            ec_free <= 0;
        end else if (d_valid && exp_cause() == 4'b0) begin
            if (d_wr && d_dst != 0) ready[d_dst] <= cyc + 1 + int'(d_tnew);
            if (d_md_start) md_free <= cyc + 2 + (d_md_div ? DIV : MULT);
            if (d_mtc0 && d_cp0_rd == 5'd14) ec_free <= cyc + 1 + EWIN;
        end
    end

    always @(negedge clk) begin
        logic [3:0] e;
        e = exp_cause();
        check("model_stall", {63'b0, stall}, {63'b0, |e});
        check("model_cause", {60'b0, stall_cause}, {60'b0, e});
        check("model_md_busy", {63'b0, md_busy}, {63'b0, rem(md_free) != 0});
        check("model_pending", {32'b0, pending}, {32'b0, exp_pending()});
    end

    task automatic clear_d();
        d_valid = 0; d_wr = 0; d_md_start = 0; d_md_div = 0; d_md_use = 0;
        d_mtc0 = 0; d_eret = 0; d_rs = 0; d_rt = 0; d_dst = 0; d_cp0_rd = 0;
        d_tuse_rs = 2'b11; d_tuse_rt = 2'b11; d_tnew = 0;
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic op_load(input logic [4:0] dst);
        clear_d(); d_valid = 1; d_wr = 1; d_dst = dst; d_tnew = 2'd2;
    endtask

    task automatic op_alu(input logic [4:0] rs, input logic [1:0] urs,
                          input logic [4:0] rt, input logic [1:0] urt, input logic [4:0] dst);
        clear_d(); d_valid = 1; d_rs = rs; d_tuse_rs = urs; d_rt = rt; d_tuse_rt = urt;
        d_wr = (dst != 0); d_dst = dst; d_tnew = 2'd1;
    endtask

    task automatic op_md(input logic is_div);
        clear_d(); d_valid = 1; d_md_start = 1; d_md_div = is_div; d_md_use = 1;
    endtask

    task automatic op_mflo();
        clear_d(); d_valid = 1; d_md_use = 1; d_wr = 1; d_dst = 5'd8; d_tnew = 2'd1;
    endtask

    task automatic op_mtc0(input logic [4:0] rd);
        clear_d(); d_valid = 1; d_mtc0 = 1; d_cp0_rd = rd;
    endtask

    task automatic op_eret();
        clear_d(); d_valid = 1; d_eret = 1;
    endtask

    // Hold the driven instruction until it issues; returns stall cycles seen.
    task automatic expect_issue(input string name, input int exp_stalls, input logic [3:0] exp_c);
        int s;
        logic [3:0] seen;
        bit done;
        s = 0; seen = '0; done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (!stall) done = 1;
            else begin s++; seen |= stall_cause; end
            @(posedge clk); #1;
        end
        if (!done) begin
            n_checks++; n_fails++;
            $display("FAIL %s_timeout: still stalled after 40 cycles, required issue", name);
        end
        clear_d();
        check({name, "_stalls"}, s, exp_stalls);
        check({name, "_cause"}, {60'b0, seen}, {60'b0, exp_c});
    endtask

    initial begin
        clear_d();
        flush = 0;
        reset = 0;
        step(3);
        #2;
        check("reset_stall", {63'b0, stall}, 0);
        check("reset_md_busy", {63'b0, md_busy}, 0);
        check("reset_pending", {32'b0, pending}, 0);
        reset = 1;
        step(1);

        op_load(5);              expect_issue("load_r5_a", 0, 4'b0000);
        check("pending_r5", {32'b0, pending}, 64'h20);
        op_alu(5, 2'd1, 0, 2'b11, 6); expect_issue("add_rs_r5", 1, 4'b0001);
        step(4);

        op_load(5);              expect_issue("load_r5_b", 0, 4'b0000);
        op_alu(0, 2'b11, 5, 2'd0, 0); expect_issue("beq_rt_r5", 2, 4'b0010);
        step(4);

        op_md(1);                expect_issue("div", 0, 4'b0000);
        op_mflo();               expect_issue("mflo_div", 11, 4'b0100);
        check("md_busy_after_div", {63'b0, md_busy}, 0);
        op_md(0);                expect_issue("mult", 0, 4'b0000);
        op_mflo();               expect_issue("mflo_mult", 6, 4'b0100);
        step(2);

        op_mtc0(5'd14);          expect_issue("mtc0_epc", 0, 4'b0000);
        op_eret();               expect_issue("eret_epc", 2, 4'b1000);
        step(3);
        op_mtc0(5'd12);          expect_issue("mtc0_sr", 0, 4'b0000);
        op_eret();               expect_issue("eret_sr", 0, 4'b0000);

        op_load(5);              expect_issue("load_r5_c", 0, 4'b0000);
        flush = 1; step(1); flush = 0;
        check("pending_after_flush", {32'b0, pending}, 0);
        op_alu(5, 2'd1, 0, 2'b11, 0); expect_issue("add_after_flush", 0, 4'b0000);
        op_load(0);              expect_issue("load_r0", 0, 4'b0000);
        check("pending_r0", {32'b0, pending}, 0);
        op_alu(0, 2'd0, 0, 2'd0, 0); expect_issue("use_r0", 0, 4'b0000);
        op_load(9); flush = 1; step(1); flush = 0; clear_d();
        op_alu(9, 2'd0, 0, 2'b11, 0); expect_issue("load_blocked_by_flush", 0, 4'b0000);
        op_md(0);                expect_issue("mult_b", 0, 4'b0000);
        flush = 1; step(1); flush = 0;
        op_mflo();               expect_issue("mflo_flush_keeps_md", 5, 4'b0100);
        step(2);

        op_md(1);                expect_issue("div_b", 0, 4'b0000);
        step(2);
        op_load(7);              expect_issue("load_r7", 0, 4'b0000);
        check("pending_r7", {32'b0, pending}, 64'h80);
        op_alu(7, 2'd0, 0, 2'b11, 0); d_md_use = 1;
        #1;
        check("pre_reset_cause", {60'b0, stall_cause}, 64'h5);
        #1; reset = 0; #1;
        check("async_reset_stall", {63'b0, stall}, 0);
        check("async_reset_cause", {60'b0, stall_cause}, 0);
        check("async_reset_md_busy", {63'b0, md_busy}, 0);
        check("async_reset_pending", {32'b0, pending}, 0);
        step(1);
        reset = 1;
        op_alu(7, 2'd0, 0, 2'b11, 0); d_md_use = 1;
        expect_issue("after_reset", 0, 4'b0000);
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
